// File: rtl/mux21_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
// State encodings and requester index constants.
package mux21_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arbState_t;

  localparam int unsigned IDX0 = 0;
  localparam int unsigned IDX1 = 1;

endpackage

// File: rtl/mux21_arbiter_if.sv
// Request/data/grant bundle between two requesters and the shared mux arbiter.
// master = requester side, slave = arbiter side.
interface mux21_arbiter_if #(
  parameter int W = 8
);

  logic [1:0]   req;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic [1:0]   grant;
  logic         sel;
  logic         valid;
  logic [W-1:0] out;

  modport master (
    output req, in0, in1,
    input  grant, sel, valid, out
  );

  modport slave (
    input  req, in0, in1,
    output grant, sel, valid, out
  );

endinterface

// File: rtl/mux21_arbiter_data.sv
// W-bit 2:1 data mux steered by the arbiter select.
// Purely combinational.
module mux21_data #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux21_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 data mux.
// Grant is registered (1 cycle after req); a holder is preempted after QUANTUM cycles when the other side waits.
module mux21_arbiter
  import mux21_arb_pkg::*;
#(
  parameter int W       = 8,
  parameter int QUANTUM = 4
) (
  input  logic             clk,
  input  logic             reset,
  mux21_arbiter_if.slave   bus
);

  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [CW-1:0] QMAX = CW'(QUANTUM - 1);

  arbState_t     stateQ, stateNext;
  logic [CW-1:0] cntQ, cntNext;
  logic          lastQ;
  logic          selQ;
  logic [W-1:0]  dataOut;

  always_comb begin
    stateNext = stateQ;
    cntNext   = cntQ;
    unique case (stateQ)
      IDLE: begin
        unique case (bus.req)
          2'b01:   stateNext = OWN0;
          2'b10:   stateNext = OWN1;
          // tie goes to whoever did not own last
          2'b11:   stateNext = lastQ ? OWN0 : OWN1;
          default: stateNext = IDLE;
        endcase
      end
      OWN0: begin
        if (!bus.req[IDX0]) begin
          stateNext = bus.req[IDX1] ? OWN1 : IDLE;
        end else if (cntQ != QMAX) begin
          cntNext = cntQ + CW'(1);
        end else if (bus.req[IDX1]) begin
          stateNext = OWN1;
        end
      end
      OWN1: begin
        if (!bus.req[IDX1]) begin
          stateNext = bus.req[IDX0] ? OWN0 : IDLE;
        end else if (cntQ != QMAX) begin
          cntNext = cntQ + CW'(1);
        end else if (bus.req[IDX0]) begin
          stateNext = OWN0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      lastQ  <= 1'b1;
      selQ   <= 1'b0;
    end else begin
      stateQ <= stateNext;
      cntQ   <= (stateNext != stateQ) ? '0 : cntNext;
      if (stateNext == OWN0 && stateQ != OWN0) begin
        lastQ <= 1'b0;
        selQ  <= 1'b0;
      end else if (stateNext == OWN1 && stateQ != OWN1) begin
        lastQ <= 1'b1;
        selQ  <= 1'b1;
      end
    end
  end

  assign bus.grant[IDX0] = (stateQ == OWN0);
  assign bus.grant[IDX1] = (stateQ == OWN1);
  assign bus.valid       = (stateQ == OWN0) || (stateQ == OWN1);
  assign bus.sel         = selQ;

  mux21_data #(.W(W)) uData (
    .sel (selQ),
    .in0 (bus.in0),
    .in1 (bus.in1),
    .out (dataOut)
  );

  assign bus.out = dataOut;

endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed bench for mux21_arbiter: a QUANTUM=4 instance and a QUANTUM=1 instance,
// expected grant/sel/valid/out queued per step and compared one cycle later.
module tb_mux21_arbiter;

  typedef struct packed {
    logic [1:0] grant;
    logic       sel;
    logic       valid;
    logic [7:0] out;
  } exp_t;

  logic clk = 1'b0;
  logic rstA = 1'b1;
  logic rstB = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mux21_arbiter_if #(.W(8)) busA ();
  mux21_arbiter_if #(.W(8)) busB ();

  mux21_arbiter #(.W(8), .QUANTUM(4)) dutA (
    .clk   (clk),
    .reset (rstA),
    .bus   (busA.slave)
  );

  mux21_arbiter #(.W(8), .QUANTUM(1)) dutB (
    .clk   (clk),
    .reset (rstB),
    .bus   (busB.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expectation, sample #1 after the edge.
  task automatic step(input bit useB, input logic r, input logic [1:0] rq,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] eg, input logic es, input logic ev,
                      input string tag);
    exp_t e;
    logic [1:0] g;
    logic       s, v;
    logic [7:0] o;
    if (useB) begin
      rstB = r; busB.req = rq; busB.in0 = a; busB.in1 = b;
    end else begin
      rstA = r; busA.req = rq; busA.in0 = a; busA.in1 = b;
    end
    sb.push_back('{grant: eg, sel: es, valid: ev, out: (es ? b : a)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (useB) begin
      g = busB.grant; s = busB.sel; v = busB.valid; o = busB.out;
    end else begin
      g = busA.grant; s = busA.sel; v = busA.valid; o = busA.out;
    end
    chk({tag, "_grant"}, 32'(g), 32'(e.grant));
    chk({tag, "_sel"},   32'(s), 32'(e.sel));
    chk({tag, "_valid"}, 32'(v), 32'(e.valid));
    chk({tag, "_out"},   32'(o), 32'(e.out));
    chk({tag, "_not11"}, 32'(g == 2'b11), 32'(0));
    chk({tag, "_vldOr"}, 32'(v), 32'(|g));
  endtask

  initial begin
    busA.req = 2'b00; busA.in0 = '0; busA.in1 = '0;
    busB.req = 2'b00; busB.in0 = '0; busB.in1 = '0;

    // 1: reset held with req=11, then first grant goes to requester 0
    step(0, 1, 2'b11, 8'hA5, 8'h00, 2'b00, 0, 0, "rst0");
    step(0, 1, 2'b11, 8'hA5, 8'h00, 2'b00, 0, 0, "rst1");
    step(0, 0, 2'b11, 8'hA5, 8'h00, 2'b01, 0, 1, "first");

    // 2: only requester 1; holding it must not time out
    for (int i = 0; i < 11; i++)
      step(0, 0, 2'b10, 8'hA5, 8'h3C, 2'b10, 1, 1, "only1");
    step(0, 0, 2'b00, 8'hA5, 8'h3C, 2'b00, 1, 0, "idleKeepSel");

    // 3: both requesting from IDLE -> 4-cycle rotation
    for (int i = 0; i < 12; i++) begin
      if (((i / 4) % 2) == 1)
        step(0, 0, 2'b11, 8'h11, 8'h22, 2'b10, 1, 1, "rr");
      else
        step(0, 0, 2'b11, 8'h11, 8'h22, 2'b01, 0, 1, "rr");
    end

    // 4: owner 0 drops while 1 raises -> direct hand-over
    step(0, 0, 2'b01, 8'h11, 8'h22, 2'b01, 0, 1, "own0Sat");
    step(0, 0, 2'b10, 8'h11, 8'h22, 2'b10, 1, 1, "handover");

    // 5: reset pulse during OWN1 cycle 2
    step(0, 0, 2'b11, 8'h11, 8'h22, 2'b10, 1, 1, "own1c2");
    step(0, 1, 2'b11, 8'h11, 8'h22, 2'b00, 0, 0, "midRst");
    step(0, 0, 2'b11, 8'h11, 8'h22, 2'b01, 0, 1, "postRst");
    step(0, 0, 2'b00, 8'h11, 8'h22, 2'b00, 0, 0, "idleA");

    // 6: QUANTUM=1 alternates every cycle
    step(1, 1, 2'b11, 8'h5A, 8'hC3, 2'b00, 0, 0, "qRst");
    for (int i = 0; i < 6; i++) begin
      if ((i % 2) == 1)
        step(1, 0, 2'b11, 8'h5A, 8'hC3, 2'b10, 1, 1, "q1alt");
      else
        step(1, 0, 2'b11, 8'h5A, 8'hC3, 2'b01, 0, 1, "q1alt");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
